// File: rtl/lfsr_arb_pkg.sv
// lfsr_arb_pkg: shared state encoding and constants for lfsr_rand_arbiter
package lfsr_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, PRESENT = 2'd2} state_t;
  localparam int STUCK_RUN_MAX = 6;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/lfsr_rand_arbiter_if.sv
// lfsr_rand_arbiter_if: request/ack and random-word delivery bundle
interface lfsr_rand_arbiter_if
  import lfsr_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [NUM_REQ-1:0] grant;
  logic [WIDTH-1:0] rand_data;
  logic rand_valid;
  logic busy;
  logic lfsr_err;
  modport master(output req, ack, input grant, rand_data, rand_valid, busy, lfsr_err);
  modport slave(input req, ack, output grant, rand_data, rand_valid, busy, lfsr_err);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at rr_ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [PW-1:0]      idx,
  output logic               valid
);
  logic [PW-1:0] c;
  // scan downward so the candidate closest to rr_ptr is written last and wins
  always_comb begin
    pick = '0;
    idx = '0;
    valid = 1'b0;
    c = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[c]) begin
        pick = '0;
        pick[c] = 1'b1;
        idx = c;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter: round-robin sharing of one LFSR bit stream as WIDTH-bit words; LFSR_ARB_STUCK_DET_EN adds stuck-stream detection
module lfsr_rand_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clock,
  input logic reset,
  input logic rnd_in,
  lfsr_rand_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state;
  logic [NUM_REQ-1:0] grant, pick;
  logic [PW-1:0] rr_ptr, gidx, pick_idx, nxt_ptr;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rand_data;
  logic rand_valid, pick_valid, lfsr_err;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(bus.req),
    .rr_ptr(rr_ptr),
    .pick(pick),
    .idx(pick_idx),
    .valid(pick_valid)
  );
  assign nxt_ptr = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  assign bus.grant = grant;
  assign bus.rand_data = rand_data;
  assign bus.rand_valid = rand_valid;
  assign bus.busy = state != IDLE;
  assign bus.lfsr_err = lfsr_err;
`ifdef LFSR_ARB_STUCK_DET_EN
  logic prev;
  logic [2:0] run, run_nxt;
  assign run_nxt = (run != '0 && rnd_in == prev) ? ((run == 3'(STUCK_RUN_MAX)) ? run : run + 1'b1) : 3'd1;
  // count consecutive identical stream bits; a long run latches the error until reset
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      prev <= 1'b0;
      run <= '0;
      lfsr_err <= 1'b0;
    end else begin
      prev <= rnd_in;
      run <= run_nxt;
      if (run_nxt == 3'(STUCK_RUN_MAX)) lfsr_err <= 1'b1;
    end
`else
  assign lfsr_err = 1'b0;
`endif
  // grant in IDLE, shift MSB-first in FILL, hold in PRESENT until ack or abandon
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      gidx <= '0;
      rand_data <= '0;
      rand_valid <= 1'b0;
      rr_ptr <= '0;
      cnt <= '0;
    end else case (state)
      IDLE: if (pick_valid && !lfsr_err) begin
        grant <= pick;
        gidx <= pick_idx;
        rand_data <= '0;
        cnt <= '0;
        state <= FILL;
      end
      FILL: if (!bus.req[gidx]) begin
        state <= IDLE;
        grant <= '0;
        rr_ptr <= nxt_ptr;
      end else begin
        rand_data <= {rand_data[WIDTH-2:0], rnd_in};
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          rand_valid <= 1'b1;
          state <= PRESENT;
        end
      end
      PRESENT: if (bus.ack[gidx] || !bus.req[gidx]) begin
        state <= IDLE;
        grant <= '0;
        rand_valid <= 1'b0;
        rr_ptr <= nxt_ptr;
      end
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// tb_lfsr_rand_arbiter: directed stimulus with a word-level reference model
module tb_lfsr_rand_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rnd_in = 1'b0;
  lfsr_rand_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
  lfsr_rand_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .rnd_in(rnd_in),
    .bus(bus)
  );
  always #5 clock = ~clock;
  int total = 0;
  int passes = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  bit ovr[$];
  bit last = 1'b0;
  int run = 0;
  // advance to the next falling edge and present the next stream bit (runs kept short unless forced)
  task automatic step();
    @(negedge clock);
    if (ovr.size() > 0) rnd_in = ovr.pop_front();
    else rnd_in = (run >= 3) ? ~last : 1'($urandom_range(0, 1));
    run = (rnd_in == last) ? run + 1 : 1;
    last = rnd_in;
  endtask
  task automatic wait_grant();
    for (int i = 0; i < 20 && bus.grant == '0; i++) step();
    chk("wait_grant", 32'(bus.grant != '0), 1);
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 20 && !bus.rand_valid; i++) step();
    chk("wait_valid", 32'(bus.rand_valid), 1);
  endtask
  logic [N-1:0] s_req = '0, s_ack = '0;
  logic s_rnd = 1'b0, s_rst = 1'b0;
  always @(posedge clock) begin
    s_req <= bus.req;
    s_ack <= bus.ack;
    s_rnd <= rnd_in;
    s_rst <= reset;
  end
  int owner = -1;
  int ptr = 0;
  int mrun = 0;
  bit mprev = 1'b0, merr = 1'b0, nerr;
  bit q[$];
  logic [31:0] word;
  // reference: owner index plus the list of bits collected for it; compared every cycle
  always @(negedge clock) begin
    if (!reset || !s_rst) begin
      owner = -1;
      ptr = 0;
      mrun = 0;
      mprev = 1'b0;
      merr = 1'b0;
      q.delete();
    end else begin
      nerr = merr;
`ifdef LFSR_ARB_STUCK_DET_EN
      mrun = (mrun > 0 && s_rnd == mprev) ? mrun + 1 : 1;
      mprev = s_rnd;
      if (mrun >= 6) nerr = 1'b1;
`endif
      if (owner < 0) begin
        if (s_req != '0 && !merr)
          for (int k = 0; k < N; k++)
            if (s_req[(ptr + k) % N]) begin
              owner = (ptr + k) % N;
              q.delete();
              break;
            end
      end else if (!s_req[owner] || (q.size() == W && s_ack[owner])) begin
        ptr = (owner + 1) % N;
        owner = -1;
      end else if (q.size() < W) q.push_back(s_rnd);
      merr = nerr;
      chk("grant", 32'(bus.grant), owner < 0 ? 0 : (1 << owner));
      chk("rand_valid", 32'(bus.rand_valid), 32'(owner >= 0 && q.size() == W));
      chk("busy", 32'(bus.busy), 32'(owner >= 0));
      chk("lfsr_err", 32'(bus.lfsr_err), 32'(merr));
      if (owner >= 0 && q.size() == W) begin
        word = 0;
        for (int k = 0; k < W; k++) word = word + (32'(q[k]) << (W - 1 - k));
        chk("rand_data", 32'(bus.rand_data), word);
      end
    end
  end
  logic [N-1:0] rr_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  initial begin
    bus.req = '0;
    bus.ack = '0;
    repeat (2) step();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_valid", 32'(bus.rand_valid), 0);
    chk("rst_data", 32'(bus.rand_data), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.lfsr_err), 0);
    #1 reset = 1'b1;
    step();
    bus.req = 4'b0001;
    ovr = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    step();
    chk("single_grant", 32'(bus.grant), 32'h1);
    repeat (7) step();
    chk("single_not_yet", 32'(bus.rand_valid), 0);
    step();
    chk("single_valid", 32'(bus.rand_valid), 1);
    chk("single_data", 32'(bus.rand_data), 32'hB2);
    bus.ack = 4'b0001;
    step();
    chk("single_ack_grant", 32'(bus.grant), 0);
    chk("single_ack_valid", 32'(bus.rand_valid), 0);
    bus.ack = '0;
    bus.req = 4'b0011;
    step();
    chk("ptr_after_ack", 32'(bus.grant), 32'h2);
    wait_valid();
    bus.ack = 4'b0010;
    step();
    bus.ack = '0;
    bus.req = 4'b0100;
    wait_valid();
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_grant", 32'(bus.grant), 0);
    chk("arst_valid", 32'(bus.rand_valid), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    step();
    bus.req = 4'b1111;
    #1 reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant();
      chk("rr_order", 32'(bus.grant), 32'(rr_exp[k]));
      wait_valid();
      if (k == 2) begin
        bus.ack = 4'b0001;
        step();
        bus.ack = '0;
        step();
        chk("wrong_ack_valid", 32'(bus.rand_valid), 1);
        chk("wrong_ack_grant", 32'(bus.grant), 32'h4);
      end
      bus.ack = rr_exp[k];
      step();
      bus.ack = '0;
    end
    bus.req = '0;
    step();
    bus.req = 4'b0100;
    step();
    chk("abandon_grant", 32'(bus.grant), 32'h4);
    repeat (3) step();
    bus.req = '0;
    step();
    chk("abandon_grant0", 32'(bus.grant), 0);
    chk("abandon_valid", 32'(bus.rand_valid), 0);
    chk("abandon_busy", 32'(bus.busy), 0);
    bus.req = 4'b1100;
    step();
    chk("abandon_next", 32'(bus.grant), 32'h8);
    wait_valid();
    bus.ack = 4'b1000;
    bus.req = '0;
    step();
    bus.ack = '0;
    chk("ack_drop_grant", 32'(bus.grant), 0);
    bus.req = 4'b0011;
    step();
    chk("ptr_wrap", 32'(bus.grant), 32'h1);
    wait_valid();
    bus.ack = 4'b0001;
    step();
    bus.ack = '0;
    bus.req = '0;
    step();
    ovr = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    repeat (7) step();
    chk("stuck_run5", 32'(bus.lfsr_err), 0);
    step();
`ifdef LFSR_ARB_STUCK_DET_EN
    chk("stuck_run6", 32'(bus.lfsr_err), 1);
`else
    chk("stuck_run6", 32'(bus.lfsr_err), 0);
`endif
    bus.req = 4'b0001;
    repeat (3) step();
`ifdef LFSR_ARB_STUCK_DET_EN
    chk("stuck_no_grant", 32'(bus.grant), 0);
`else
    chk("stuck_no_grant", 32'(bus.grant), 32'h1);
`endif
    bus.req = '0;
    repeat (2) step();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
- Shares the single free-running 5-bit LFSR random bit stream (`rnd`) among NUM_REQ requesters.
- Serially assembles a WIDTH-bit random word for one requester at a time.
- Arbitration is round-robin; delivery uses a valid/ack handshake.
- Sits between the LFSR instance and the consumer blocks that need random words.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, bits per delivered random word (2..16)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rnd_in  in  1  random bit from the LFSR `rnd` output; one new bit per clock
- req  in  NUM_REQ  level request per requester; held until ack or abandoned
- ack  in  NUM_REQ  per-requester acknowledge; only ack[granted] is honoured
- grant  out  NUM_REQ  one-hot owner of the current word; all zero when idle
- rand_data  out  WIDTH  assembled random word
- rand_valid  out  1  rand_data is complete for the granted requester
- busy  out  1  state != IDLE
- lfsr_err  out  1  sticky stuck-stream flag (feature only; otherwise tied 0)

Behaviour:
- Reset (async, reset=0): state IDLE, grant=0, rand_valid=0, rand_data=0, rr_ptr=0, cnt=0, busy=0, lfsr_err=0.
- States: IDLE, FILL, PRESENT.
- IDLE, when req!=0:
  - Select the first set req[i] scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Next edge: grant<=onehot(i), rand_data<=0, cnt<=0, state<=FILL.
- FILL, each cycle:
  - rand_data <= {rand_data[WIDTH-2:0], rnd_in}; cnt++.
  - On the shift where cnt==WIDTH-1: rand_valid<=1, state<=PRESENT.
  - rand_valid therefore rises exactly WIDTH cycles after grant rises.
  - The first bit captured is rnd_in in the cycle grant is first high. That bit ends at rand_data[WIDTH-1] (MSB-first).
- PRESENT: rand_data is held stable.
  - On ack[g]=1 (g = granted index): rand_valid<=0, grant<=0, rr_ptr<=(g+1) mod NUM_REQ, state<=IDLE.
  - ack on non-granted bits is ignored.
  - rand_valid and ack in the same cycle constitutes the transfer.
- Abandon: req[g] deasserted while in FILL or PRESENT.
  - Next edge: state IDLE, grant=0, rand_valid=0, rr_ptr advances as for ack.
  - No word is delivered; rand_data retains its last value.
- IDLE always spends at least one cycle between grants. There is no back-to-back grant on the ack edge.
- Simultaneous ack[g] and req[g] deassert in PRESENT: treated as a completed transfer; same next state.
- Requests arriving during FILL/PRESENT wait; fairness is guaranteed by rr_ptr.
- rr_ptr wraps from NUM_REQ-1 to 0.
- cnt width is $clog2(WIDTH)+1; no overflow is possible.
- The LFSR is never stalled. The block only samples it, so words to different requesters come from disjoint bit windows.

Optional Feature:
- Macro: LFSR_ARB_STUCK_DET_EN.
- With the macro defined:
  - A run counter tracks consecutive identical rnd_in values every cycle, in all states.
  - A run of 6 or more sets lfsr_err=1, which stays sticky until reset. A correct 5-bit m-sequence never exceeds 5.
  - While lfsr_err=1, IDLE issues no new grants.
  - A word already in PRESENT is still completed.
- Without the macro: lfsr_err is tied 0, no run counter is built, and arbitration is unaffected.

Decomposition:
- Package lfsr_arb_pkg:
  - state enum (IDLE=2'd0, FILL=2'd1, PRESENT=2'd2)
  - STUCK_RUN_MAX=6
  - default NUM_REQ/WIDTH constants
- Sub-module rr_arbiter (NUM_REQ):
  - Combinational inputs: req, rr_ptr. Output: one-hot pick plus a valid flag.
  - Instantiated once; the FSM registers its result.

Test Plan:
- Single requester: req=4'b0001, rnd_in driven 1,0,1,1,0,0,1,0 from the grant cycle.
  - Expect rand_valid 8 cycles after grant, rand_data=8'hB2.
  - ack[0] -> grant=0 and rand_valid=0 next cycle; rr_ptr=1.
- Round robin: req=4'b1111 held, ack each word. Expect grant order 0001,0010,0100,1000,0001.
- Wrong ack: in PRESENT with grant=0100, pulse ack=4'b0001. Expect no change; rand_valid stays 1 and data is stable.
- Abandon: drop req[2] at FILL cnt=3. Expect IDLE next edge with no rand_valid pulse; next grant goes to requester 3 if requested.
- Async reset mid-PRESENT: reset=0 between edges. Expect grant=0, rand_valid=0, busy=0 immediately; rr_ptr=0 after release.
- With LFSR_ARB_STUCK_DET_EN: rnd_in held 1 for 6 cycles. Expect lfsr_err=1 on the 6th and no further grants; without the macro lfsr_err stays 0.
